// File: rtl/sram_ctrl_pkg.sv
// Shared types and default geometry for the clockport SRAM initiator.
package sram_ctrl_pkg;

    localparam int DEF_AW         = 16;
    localparam int DEF_DW         = 8;
    localparam int DEF_RD_WAIT    = 2;
    localparam int DEF_WR_WAIT    = 2;
    localparam int DEF_TURNAROUND = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        TURN
    } state_t;

endpackage

// File: rtl/sram_ctrl.sv
// Single-beat request to asynchronous SRAM strobe sequencer with programmable
// wait states; every strobe toward the SRAM comes straight from a flop.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_WAIT    = DEF_RD_WAIT,
    parameter int WR_WAIT    = DEF_WR_WAIT,
    parameter int TURNAROUND = DEF_TURNAROUND
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_rvalid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_wdone,
    output logic [AW-1:0] sram_a,
    output logic [DW-1:0] sram_d_out,
    output logic          sram_d_oe,
    input  logic [DW-1:0] sram_d_in,
    output logic          sram_cs_n,
    output logic          sram_we_n,
    output logic          sram_oe_n
);

    localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int WCW      = $clog2(MAX_WAIT + 1);
    localparam int TCW      = (TURNAROUND > 0) ? $clog2(TURNAROUND + 1) : 1;

    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("sram_ctrl: RD_WAIT must be >= 1");
    end
    if (WR_WAIT < 1) begin : g_bad_wr_wait
        $error("sram_ctrl: WR_WAIT must be >= 1");
    end
    if (TURNAROUND < 0) begin : g_bad_turnaround
        $error("sram_ctrl: TURNAROUND must be >= 0");
    end

    state_t         state, state_d;
    logic [WCW-1:0] wait_cnt, wait_cnt_d;
    logic [TCW-1:0] turn_cnt, turn_cnt_d;
    logic           we_q, we_d;
    logic           accept;
    logic           in_cycle_d;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        turn_cnt_d = turn_cnt;
        we_d       = we_q;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    we_d    = req_we;
                end
            end
            SETUP: begin
                state_d    = ACCESS;
                wait_cnt_d = we_q ? WCW'(WR_WAIT) : WCW'(RD_WAIT);
            end
            ACCESS: begin
                if (wait_cnt == WCW'(1)) begin
                    state_d = HOLD;
                end else begin
                    wait_cnt_d = wait_cnt - WCW'(1);
                end
            end
            HOLD: begin
                if (TURNAROUND > 0) begin
                    state_d    = TURN;
                    turn_cnt_d = TCW'(TURNAROUND);
                end else begin
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (turn_cnt <= TCW'(1)) begin
                    state_d = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt - TCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        in_cycle_d = state_d inside {SETUP, ACCESS, HOLD};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            turn_cnt <= '0;
            we_q     <= 1'b0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            turn_cnt <= turn_cnt_d;
            we_q     <= we_d;
        end
    end

    // Strobes are registered from the next state so they switch cleanly on
    // the same edge as the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sram_a     <= '0;
            sram_d_out <= '0;
            sram_d_oe  <= 1'b0;
            sram_cs_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            rsp_rvalid <= 1'b0;
            rsp_wdone  <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            if (accept) begin
                sram_a <= req_addr;
                if (req_we) begin
                    sram_d_out <= req_wdata;
                end
            end
            sram_cs_n  <= !in_cycle_d;
            sram_we_n  <= !((state_d == ACCESS) && we_d);
            sram_oe_n  <= !((state_d == ACCESS) && !we_d);
            sram_d_oe  <= in_cycle_d && we_d;
            rsp_rvalid <= (state_d == HOLD) && !we_d;
            rsp_wdone  <= (state_d == HOLD) && we_d;
            if ((state == ACCESS) && !we_q && (wait_cnt == WCW'(1))) begin
                rsp_rdata <= sram_d_in;
            end
        end
    end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: unit 0 uses default timing, unit 1 uses RD_WAIT=1,
// WR_WAIT=4, TURNAROUND=0; each unit drives its own behavioural SRAM.
module tb_sram_ctrl;

    localparam int AW = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req_valid [2];
    logic          req_ready [2];
    logic          req_we    [2];
    logic [AW-1:0] req_addr  [2];
    logic [DW-1:0] req_wdata [2];
    logic          rsp_rvalid[2];
    logic [DW-1:0] rsp_rdata [2];
    logic          rsp_wdone [2];
    logic [AW-1:0] sram_a    [2];
    logic [DW-1:0] sram_d_out[2];
    logic          sram_d_oe [2];
    logic [DW-1:0] sram_d_in [2];
    logic          sram_cs_n [2];
    logic          sram_we_n [2];
    logic          sram_oe_n [2];

    int checks = 0;
    int passed = 0;

    logic [DW:0]   exp_q[$];
    logic [DW-1:0] ref_mem [0:65535];

    for (genvar g = 0; g < 2; g++) begin : g_u
        sram_ctrl #(
            .AW(AW), .DW(DW),
            .RD_WAIT(g == 0 ? 2 : 1),
            .WR_WAIT(g == 0 ? 2 : 4),
            .TURNAROUND(g == 0 ? 1 : 0)
        ) u_dut (
            .clk(clk), .rst_n(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_we(req_we[g]),
            .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
            .rsp_rvalid(rsp_rvalid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_wdone(rsp_wdone[g]),
            .sram_a(sram_a[g]), .sram_d_out(sram_d_out[g]), .sram_d_oe(sram_d_oe[g]),
            .sram_d_in(sram_d_in[g]), .sram_cs_n(sram_cs_n[g]),
            .sram_we_n(sram_we_n[g]), .sram_oe_n(sram_oe_n[g])
        );

        logic [DW-1:0] mem [0:65535];
        initial for (int i = 0; i < 65536; i++) mem[i] = '0;

        assign sram_d_in[g] = (!sram_cs_n[g] && !sram_oe_n[g]) ? mem[sram_a[g]] : 'x;

        // Asynchronous SRAM: the write is committed on the rising edge of WE.
        always @(posedge sram_we_n[g]) begin
            if (rst_n && sram_cs_n[g] === 1'b0) begin
                checks++;
                if (sram_d_oe[g] !== 1'b1)
                    $display("FAIL u%0d model_write_no_data d_oe=%b required 1", g, sram_d_oe[g]);
                else
                    passed++;
                mem[sram_a[g]] = sram_d_out[g];
            end
        end

        logic [AW-1:0] prev_a;
        logic [DW-1:0] prev_dout;
        logic          prev_we_n;
        bit            prev_ok = 1'b0;

        always @(negedge clk) begin
            if (!rst_n) begin
                prev_ok = 1'b0;
            end else begin
                checks++;
                if (!sram_we_n[g] && !sram_oe_n[g])
                    $display("FAIL u%0d inv_we_oe we_n=%b oe_n=%b required not both 0", g, sram_we_n[g], sram_oe_n[g]);
                else passed++;
                checks++;
                if (sram_d_oe[g] && !sram_oe_n[g])
                    $display("FAIL u%0d inv_contention d_oe=%b oe_n=%b required not d_oe with oe_n=0", g, sram_d_oe[g], sram_oe_n[g]);
                else passed++;
                checks++;
                if ((!sram_we_n[g] || !sram_oe_n[g]) && sram_cs_n[g] !== 1'b0)
                    $display("FAIL u%0d inv_cs cs_n=%b required 0 while strobing", g, sram_cs_n[g]);
                else passed++;
                if (prev_ok) begin
                    checks++;
                    if ((sram_a[g] !== prev_a || sram_d_out[g] !== prev_dout) && (!prev_we_n || !sram_we_n[g]))
                        $display("FAIL u%0d inv_stable a=%h/%h d=%h/%h required unchanged while we_n=0",
                                 g, sram_a[g], prev_a, sram_d_out[g], prev_dout);
                    else passed++;
                end
                prev_a    = sram_a[g];
                prev_dout = sram_d_out[g];
                prev_we_n = sram_we_n[g];
                prev_ok   = 1'b1;
            end
        end
    end

    // Scoreboard for unit 0: each entry is {is_write, data}.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (rst_n && (rsp_rvalid[0] || rsp_wdone[0])) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected rvalid=%b wdone=%b required no response", rsp_rvalid[0], rsp_wdone[0]);
            end else begin
                passed++;
                e = exp_q.pop_front();
                checks++;
                if ({rsp_wdone[0], rsp_rvalid[0]} !== {e[DW], !e[DW]})
                    $display("FAIL sb_kind wdone,rvalid=%b%b required %b%b", rsp_wdone[0], rsp_rvalid[0], e[DW], !e[DW]);
                else passed++;
                if (!e[DW]) begin
                    checks++;
                    if (rsp_rdata[0] !== e[DW-1:0])
                        $display("FAIL sb_rdata got=%h required %h", rsp_rdata[0], e[DW-1:0]);
                    else passed++;
                end
            end
        end
    end

    task automatic issue(input int u, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, output int waited);
        int n = 0;
        @(negedge clk);
        req_valid[u] = 1'b1;
        req_we[u]    = we;
        req_addr[u]  = addr;
        req_wdata[u] = wd;
        while (req_ready[u] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        waited = n;
        checks++;
        if (req_ready[u] !== 1'b1) begin
            $display("FAIL u%0d accept_timeout req_ready=%b required 1 within 50 cycles", u, req_ready[u]);
        end else begin
            passed++;
            @(posedge clk);
            if (u == 0) begin
                if (we) begin
                    ref_mem[addr] = wd;
                    exp_q.push_back({1'b1, wd});
                end else begin
                    exp_q.push_back({1'b0, ref_mem[addr]});
                end
            end
        end
    endtask

    task automatic idle(input int u, input int cycles);
        @(negedge clk);
        req_valid[u] = 1'b0;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_we[u] = 1'b0; req_addr[u] = '0; req_wdata[u] = '0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            checks++;
            if ({sram_cs_n[u], sram_we_n[u], sram_oe_n[u], sram_d_oe[u], rsp_rvalid[u], rsp_wdone[u], req_ready[u]} !== 7'b1110001)
                $display("FAIL u%0d reset_ctrl got=%b required 1110001", u,
                         {sram_cs_n[u], sram_we_n[u], sram_oe_n[u], sram_d_oe[u], rsp_rvalid[u], rsp_wdone[u], req_ready[u]});
            else passed++;
            checks++;
            if ({sram_a[u], sram_d_out[u], rsp_rdata[u]} !== '0)
                $display("FAIL u%0d reset_data a=%h d_out=%h rdata=%h required 0", u, sram_a[u], sram_d_out[u], rsp_rdata[u]);
            else passed++;
        end
    endtask

    task automatic test_write_read();
        int n;
        issue(0, 1'b1, 16'h1234, 8'hA5, n);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[0] = 1'b0;
            checks++;
            if (rsp_wdone[0] !== (i == 4)) $display("FAIL wr_wdone_cycle k+%0d got=%b required %b", i, rsp_wdone[0], i == 4);
            else passed++;
            checks++;
            if (sram_we_n[0] !== !(i == 2 || i == 3)) $display("FAIL wr_we_n_cycle k+%0d got=%b required %b", i, sram_we_n[0], !(i == 2 || i == 3));
            else passed++;
            checks++;
            if (req_ready[0] !== (i == 6)) $display("FAIL wr_ready_cycle k+%0d got=%b required %b", i, req_ready[0], i == 6);
            else passed++;
        end
        issue(0, 1'b0, 16'h1234, 8'h00, n);
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[0] = 1'b0;
            checks++;
            if (rsp_rvalid[0] !== (i == 4)) $display("FAIL rd_rvalid_cycle k+%0d got=%b required %b", i, rsp_rvalid[0], i == 4);
            else passed++;
            checks++;
            if (sram_oe_n[0] !== !(i == 2 || i == 3)) $display("FAIL rd_oe_n_cycle k+%0d got=%b required %b", i, sram_oe_n[0], !(i == 2 || i == 3));
            else passed++;
            if (i == 4) begin
                checks++;
                if (rsp_rdata[0] !== 8'hA5) $display("FAIL rd_data got=%h required a5", rsp_rdata[0]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        issue(0, 1'b1, 16'h0001, 8'h11, n);
        issue(0, 1'b0, 16'h0001, 8'h00, n);
        checks++;
        if (n !== 5) $display("FAIL b2b_gap_1 waited=%0d required 5", n); else passed++;
        issue(0, 1'b1, 16'h0002, 8'h22, n);
        checks++;
        if (n !== 5) $display("FAIL b2b_gap_2 waited=%0d required 5", n); else passed++;
        issue(0, 1'b0, 16'h0002, 8'h00, n);
        checks++;
        if (n !== 5) $display("FAIL b2b_gap_3 waited=%0d required 5", n); else passed++;
        idle(0, 8);
    endtask

    task automatic test_boundary();
        int n;
        issue(0, 1'b1, 16'hFFFF, 8'h5A, n);
        issue(0, 1'b1, 16'h0000, 8'hC3, n);
        issue(0, 1'b0, 16'hFFFF, 8'h00, n);
        issue(0, 1'b0, 16'h0000, 8'h00, n);
        idle(0, 8);
        checks++;
        if (g_u[0].mem[16'hFFFF] !== 8'h5A) $display("FAIL bound_mem_ffff got=%h required 5a", g_u[0].mem[16'hFFFF]);
        else passed++;
        checks++;
        if (g_u[0].mem[16'h0000] !== 8'hC3) $display("FAIL bound_mem_0000 got=%h required c3", g_u[0].mem[16'h0000]);
        else passed++;
    endtask

    task automatic test_param_sweep();
        int n;
        int we_low = 0;
        int oe_low = 0;
        issue(1, 1'b1, 16'h0042, 8'h77, n);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[1] = 1'b0;
            if (sram_we_n[1] === 1'b0) we_low++;
            checks++;
            if (req_ready[1] !== (i >= 7)) $display("FAIL sw_wr_ready k+%0d got=%b required %b", i, req_ready[1], i >= 7);
            else passed++;
            checks++;
            if (rsp_wdone[1] !== (i == 6)) $display("FAIL sw_wdone k+%0d got=%b required %b", i, rsp_wdone[1], i == 6);
            else passed++;
        end
        checks++;
        if (we_low !== 4) $display("FAIL sw_we_width got=%0d required 4", we_low); else passed++;
        issue(1, 1'b0, 16'h0042, 8'h00, n);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (i == 1) req_valid[1] = 1'b0;
            if (sram_oe_n[1] === 1'b0) oe_low++;
            checks++;
            if (req_ready[1] !== (i >= 4)) $display("FAIL sw_rd_ready k+%0d got=%b required %b", i, req_ready[1], i >= 4);
            else passed++;
            checks++;
            if (rsp_rvalid[1] !== (i == 3)) $display("FAIL sw_rvalid k+%0d got=%b required %b", i, rsp_rvalid[1], i == 3);
            else passed++;
            if (i == 3) begin
                checks++;
                if (rsp_rdata[1] !== 8'h77) $display("FAIL sw_rdata got=%h required 77", rsp_rdata[1]);
                else passed++;
            end
        end
        checks++;
        if (oe_low !== 1) $display("FAIL sw_oe_width got=%0d required 1", oe_low); else passed++;
        issue(1, 1'b1, 16'h0043, 8'h99, n);
        issue(1, 1'b0, 16'h0043, 8'h00, n);
        checks++;
        if (n !== 6) $display("FAIL sw_b2b_after_write waited=%0d required 6", n); else passed++;
        issue(1, 1'b0, 16'h0042, 8'h00, n);
        checks++;
        if (n !== 3) $display("FAIL sw_b2b_after_read waited=%0d required 3", n); else passed++;
        idle(1, 6);
    endtask

    task automatic test_reset_mid_write();
        int n;
        issue(0, 1'b1, 16'h8000, 8'h3C, n);
        repeat (3) begin
            @(negedge clk);
            req_valid[0] = 1'b0;
        end
        checks++;
        if (sram_we_n[0] !== 1'b0) $display("FAIL rst_pre_we_n got=%b required 0", sram_we_n[0]); else passed++;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({sram_cs_n[0], sram_we_n[0], sram_oe_n[0], sram_d_oe[0]} !== 4'b1110)
            $display("FAIL rst_async_strobes cs,we,oe,d_oe=%b required 1110",
                     {sram_cs_n[0], sram_we_n[0], sram_oe_n[0], sram_d_oe[0]});
        else passed++;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (rsp_wdone[0] !== 1'b0) $display("FAIL rst_no_wdone got=%b required 0", rsp_wdone[0]); else passed++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready[0] !== 1'b1) $display("FAIL rst_ready_after got=%b required 1", req_ready[0]); else passed++;
        checks++;
        if (rsp_wdone[0] !== 1'b0) $display("FAIL rst_wdone_after got=%b required 0", rsp_wdone[0]); else passed++;
    endtask

    task automatic test_random();
        int n;
        logic we;
        logic [AW-1:0] addr;
        for (int i = 0; i < 10000; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 16'h0100 + 16'($urandom_range(0, 63));
            issue(0, we, addr, 8'($urandom_range(0, 255)), n);
        end
        idle(0, 10);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ref_mem[i] = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_boundary();
        test_param_sweep();
        test_reset_mid_write();
        test_random();
        checks++;
        if (exp_q.size() != 0) $display("FAIL sb_drain pending=%0d required 0", exp_q.size());
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #3ms;
        checks++;
        $display("FAIL watchdog simulation time limit reached");
        $display("%0d/%0d checks passed", passed, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
Synchronous initiator for the 16-bit-address, 8-bit asynchronous SRAM on the clockport board. It converts a single-beat valid/ready request interface (read or write) into correctly sequenced CS/WE/OE/address/data strobes, with programmable wait states. It guarantees that WE and OE are never active together and that there is no bus contention on D. It sits between the clockport/Pi-side bus logic and the external SRAM (or its behavioural model in simulation).

Parameters:
AW, 16, address width
DW, 8, data width
RD_WAIT, 2, cycles OE held low per read (>=1, elaboration error otherwise)
WR_WAIT, 2, cycles WE held low per write (>=1, elaboration error otherwise)
TURNAROUND, 1, idle cycles with CS high after every access (>=0)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1=write, 0=read
req_addr  in  AW  access address
req_wdata  in  DW  write data
rsp_rvalid  out  1  one-cycle pulse, rsp_rdata valid
rsp_rdata  out  DW  read data, held until next read completes
rsp_wdone  out  1  one-cycle pulse, write strobe completed
sram_a  out  AW  SRAM address
sram_d_out  out  DW  data driven to SRAM
sram_d_oe  out  1  tristate enable for sram_d_out (top level builds inout D)
sram_d_in  in  DW  data sampled from SRAM D
sram_cs_n  out  1  chip select, active low
sram_we_n  out  1  write enable, active low
sram_oe_n  out  1  output enable, active low

Behaviour:
- One clock (clk); reset asynchronous, active-low (rst_n). All sram_* outputs and rsp_* are registered (no combinational glitches toward the SRAM).
- Reset values: sram_cs_n=1, sram_we_n=1, sram_oe_n=1, sram_d_oe=0, sram_a=0, sram_d_out=0, rsp_rvalid=0, rsp_wdone=0, rsp_rdata=0, state=IDLE, so req_ready=1.
- req_ready=1 only in IDLE (decoded from state). Handshake at the rising edge where req_valid && req_ready: latch addr/we/wdata and go to SETUP. req_valid in other states is ignored; no queueing.
- States: IDLE -> SETUP -> ACCESS -> HOLD -> TURN -> IDLE. TURN is skipped when TURNAROUND=0 (HOLD -> IDLE).
- SETUP (1 cycle): cs_n=0, sram_a=addr, we_n=oe_n=1. For a write, d_oe=1 and d_out=wdata, giving data setup before WE falls.
- ACCESS: write: we_n=0 for exactly WR_WAIT cycles, with d_oe, d_out and sram_a stable. Read: oe_n=0 for exactly RD_WAIT cycles, d_oe=0. sram_d_in is captured into rsp_rdata at the clock edge that ends the last ACCESS cycle.
- Wait counter: width $clog2(max(RD_WAIT,WR_WAIT)+1). It is loaded on entry to ACCESS and decremented each cycle; ACCESS exits when it reaches 1.
- HOLD (1 cycle): we_n=oe_n=1, cs_n=0. Address and write data are held, giving hold after the WE rising edge. rsp_rvalid=1 (read) or rsp_wdone=1 (write) in this cycle only.
- TURN: cs_n=1, d_oe=0, for TURNAROUND cycles.
- Latency (RD_WAIT=2, TURNAROUND=1, accept at edge k): SETUP cycle k+1, ACCESS k+2..k+3, HOLD/rsp_rvalid k+4, TURN k+5, req_ready=1 in k+6. Throughput: one access per 3+WAIT+TURNAROUND cycles.
- Invariants, all cycles:
  - never (we_n==0 && oe_n==0)
  - never (d_oe==1 && oe_n==0)
  - we_n or oe_n low implies cs_n low
  - sram_a and d_out change only while we_n==1
- Address wrap: none; the address is passed through untouched, so 0xFFFF and 0x0000 are ordinary addresses.
- Reset mid-operation: all strobes deassert and d_oe=0 asynchronously. The pending transaction is dropped with no rsp pulse, and IDLE is entered.

Decomposition:
- Package sram_ctrl_pkg: state enum (IDLE, SETUP, ACCESS, HOLD, TURN), default AW/DW/wait constants.
- Flat module; no sub-module (the wait counter is a few lines inline).
- The top level instantiates the D tristate from sram_d_out/sram_d_oe.

Test Plan:
- Write 0xA5 to 0x1234, then read 0x1234 against the SRAM behavioural model -> rsp_rdata=0xA5; rsp_rvalid exactly in cycle k+4; rsp_wdone single pulse.
- Back-to-back requests with req_valid held high (W 0x0001=0x11, R 0x0001, W 0x0002=0x22, R 0x0002) -> reads return 0x11 and 0x22; req_ready=0 outside IDLE; model reports no "OE and WE both active" and no invalid-write messages.
- Boundary addresses: write 0xFFFF=0x5A and 0x0000=0xC3, read both back -> 0x5A and 0xC3; no aliasing.
- Parameter sweep RD_WAIT=1/WR_WAIT=4/TURNAROUND=0 -> oe_n low for exactly 1 cycle, we_n low for exactly 4 cycles; the next accept happens in the cycle after HOLD.
- Drive rst_n=0 during the second ACCESS cycle of a write -> cs_n/we_n go high and d_oe goes low without waiting for clk; no rsp_wdone; req_ready=1 on the first cycle after release.
- Assertion bench for all Behaviour invariants over 10k random requests -> zero violations; read data matches a reference array.
